// File: rtl/wb_stage_lsu.sv
// Writeback stage: registers the MEM-stage instruction, waits for load data,
// aligns/extends it, selects the writeback source and retires one instruction per commit.
module wb_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_alu,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [31:0]       i_inst,
  input  logic [1:0]        i_wb_sel,
  input  logic              i_rd_wren,
  input  logic              i_ld,
  input  logic [XLEN-1:0]   i_lsu_rdata,
  input  logic              i_lsu_rvalid,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [XLEN-1:0]   o_rd_data,
  output logic              o_rd_wren,
  output logic              o_commit,
  output logic [CNT_W-1:0]  o_instret,
  output logic              o_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMMIT  = 2'd1,
    ST_WAIT_LD = 2'd2
  } state_e;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_LD  = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;

  state_e state_q, state_d;

  logic [REG_AW-1:0] rd_q;
  logic [2:0]        f3_q;
  logic [1:0]        sel_q;
  logic              wren_q;
  logic [XLEN-1:0]   alu_q, pc4_q, imm_q;

  logic [REG_AW-1:0] rd_addr_q;
  logic [XLEN-1:0]   rd_data_q;
  logic              rd_wren_q;
  logic [CNT_W-1:0]  instret_q;
  logic              err_q;

  logic              accept;
  logic              commit_go;
  logic              err_set;
  logic [REG_AW-1:0] rd_s;
  logic [2:0]        f3_s;
  logic [1:0]        sel_s;
  logic              wren_s;
  logic [XLEN-1:0]   alu_s, pc4_s, imm_s;
  logic [XLEN-1:0]   load_s, data_s;
  logic              unused_inst;

  assign unused_inst = ^{i_inst[31:15], i_inst[6:0]};

  // Byte lane offset is taken from the low address bits; on 32-bit cores bit 2 is ignored.
  function automatic logic [XLEN-1:0] align_load(input logic [2:0] f3,
                                                 input logic [2:0] off_raw,
                                                 input logic [XLEN-1:0] rdata);
    logic [2:0]      off;
    logic [7:0]      b;
    logic [15:0]     h;
    logic [31:0]     w;
    logic [XLEN-1:0] res;
    off = (XLEN == 64) ? off_raw : {1'b0, off_raw[1:0]};
    b   = 8'(rdata >> {off, 3'b000});
    h   = 16'(rdata >> {off[2:1], 4'b0000});
    w   = 32'(rdata >> {off[2], 5'b00000});
    res = rdata;
    case (f3)
      3'b000:  res = XLEN'($signed(b));
      3'b100:  res = XLEN'(b);
      3'b001:  res = XLEN'($signed(h));
      3'b101:  res = XLEN'(h);
      3'b010:  res = XLEN'($signed(w));
      3'b110:  res = (XLEN == 64) ? XLEN'(w) : rdata;
      default: res = rdata;
    endcase
    return res;
  endfunction

  assign o_ready = (state_q != ST_WAIT_LD);
  assign accept  = i_valid && o_ready;

  // Fields come straight from the inputs when committing on the accept edge,
  // otherwise from the copy latched while waiting for load data.
  always_comb begin
    rd_s   = accept ? REG_AW'(i_inst[11:7]) : rd_q;
    f3_s   = accept ? i_inst[14:12]         : f3_q;
    sel_s  = accept ? i_wb_sel              : sel_q;
    wren_s = accept ? i_rd_wren             : wren_q;
    alu_s  = accept ? i_alu                 : alu_q;
    pc4_s  = accept ? i_pc + XLEN'(4)       : pc4_q;
    imm_s  = accept ? i_imm                 : imm_q;
    load_s = align_load(f3_s, alu_s[2:0], i_lsu_rdata);
    case (sel_s)
      SEL_ALU: data_s = alu_s;
      SEL_LD:  data_s = load_s;
      SEL_PC4: data_s = pc4_s;
      default: data_s = imm_s;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    commit_go = 1'b0;
    case (state_q)
      ST_WAIT_LD: begin
        if (i_lsu_rvalid) begin
          state_d   = ST_COMMIT;
          commit_go = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if (!i_ld || i_lsu_rvalid) begin
            state_d   = ST_COMMIT;
            commit_go = 1'b1;
          end else begin
            state_d = ST_WAIT_LD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign err_set = i_lsu_rvalid && (state_q != ST_WAIT_LD) && !(accept && i_ld);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      f3_q    <= '0;
      sel_q   <= '0;
      wren_q  <= 1'b0;
      alu_q   <= '0;
      pc4_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rd_q   <= rd_s;
        f3_q   <= f3_s;
        sel_q  <= sel_s;
        wren_q <= wren_s;
        alu_q  <= alu_s;
        pc4_q  <= pc4_s;
        imm_q  <= imm_s;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wren_q <= 1'b0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_wren_q <= 1'b0;
      if (commit_go) begin
        rd_addr_q <= rd_s;
        rd_data_q <= data_s;
        rd_wren_q <= wren_s && (rd_s != '0);
      end
      if (state_q == ST_COMMIT) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_commit  = (state_q == ST_COMMIT);
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;
  assign o_rd_wren = rd_wren_q;
  assign o_instret = instret_q;
  assign o_err     = err_q;

endmodule
